// File: rtl/fm_pingpong_buf.sv
// Two-bank ping-pong feature-map buffer with producer/consumer bank handoff.
// Define FM_BUF_OREG_EN to add an output register (read latency 2 instead of 1).
module fm_pingpong_buf #(
    parameter int unsigned DATA_W = 1344,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_done,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_done,
    output logic              rd_avail,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [1:0]        full_cnt,
    output logic              err
);

    // Encoding doubles as the full-bank count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        BOTH  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   wr_sel_q, wr_sel_d;
    logic   rd_sel_q, rd_sel_d;
    logic   err_q;

    logic wr_in_range, rd_in_range;
    logic wr_acc, rd_acc;
    logic wr_commit, rd_release;
    logic proto_err;

    logic [DATA_W-1:0] mem [2][DEPTH];

    logic              v1_q;
    logic [DATA_W-1:0] d1_q;

    assign wr_ready = (state_q != BOTH);
    assign rd_avail = (state_q != EMPTY);
    assign full_cnt = 2'(state_q);
    assign err      = err_q;

    assign wr_in_range = (32'(wr_addr) < DEPTH);
    assign rd_in_range = (32'(rd_addr) < DEPTH);

    assign wr_acc     = wr_en & wr_ready & wr_in_range;
    assign rd_acc     = rd_en & rd_avail & rd_in_range;
    assign wr_commit  = wr_done & wr_ready;
    assign rd_release = rd_done & rd_avail;

    assign proto_err = ((wr_en | wr_done) & ~wr_ready)
                     | ((rd_en | rd_done) & ~rd_avail);

    always_comb begin
        state_d  = state_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        if (wr_commit) begin
            wr_sel_d = ~wr_sel_q;
        end
        if (rd_release) begin
            rd_sel_d = ~rd_sel_q;
        end
        unique case (state_q)
            EMPTY: begin
                if (wr_commit) begin
                    state_d = ONE;
                end
            end
            ONE: begin
                if (wr_commit && !rd_release) begin
                    state_d = BOTH;
                end else if (!wr_commit && rd_release) begin
                    state_d = EMPTY;
                end
            end
            BOTH: begin
                if (rd_release) begin
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            err_q    <= err_q | proto_err;
        end
    end

    // Storage stays unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_sel_q][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            d1_q <= '0;
        end else begin
            v1_q <= rd_acc;
            if (rd_acc) begin
                d1_q <= mem[rd_sel_q][rd_addr];
            end
        end
    end

`ifdef FM_BUF_OREG_EN
    logic              v2_q;
    logic [DATA_W-1:0] d2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0;
            d2_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                d2_q <= d1_q;
            end
        end
    end

    assign rd_valid = v2_q;
    assign rd_data  = d2_q;
`else
    assign rd_valid = v1_q;
    assign rd_data  = d1_q;
`endif

endmodule

// File: tb/tb_fm_pingpong_buf.sv
// Scoreboard bench for fm_pingpong_buf: bank handoff, errors, read latency.
module tb_fm_pingpong_buf;

    localparam int DW    = 1344;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef FM_BUF_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_done;
    logic          wr_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_done;
    logic          rd_avail;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [1:0]    full_cnt;
    logic          err;

    fm_pingpong_buf #(
        .DATA_W(DW),
        .DEPTH (DEPTH),
        .ADDR_W(AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_done (wr_done),
        .wr_ready(wr_ready),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_done (rd_done),
        .rd_avail(rd_avail),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .full_cnt(full_cnt),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [DW-1:0] mk(input logic [15:0] base, input int i);
        logic [DW-1:0] v;
        logic [15:0]   w;
        w = base + 16'(i);
        v = '0;
        v[15:0] = w;
        v[DW-1 -: 16] = ~w;
        return v;
    endfunction

    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (rd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected got lo=%h hi=%h @%0d",
                         rd_data[15:0], rd_data[DW-1 -: 16], cyc);
            end else begin
                e = sb.pop_front();
                if (rd_data !== e.data || cyc != e.due) begin
                    failures++;
                    $display("FAIL rd_data got lo=%h hi=%h @%0d exp lo=%h hi=%h @%0d",
                             rd_data[15:0], rd_data[DW-1 -: 16], cyc,
                             e.data[15:0], e.data[DW-1 -: 16], e.due);
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            failures++;
            e = sb.pop_front();
            $display("FAIL rd_missing got no rd_valid exp lo=%h due @%0d now @%0d",
                     e.data[15:0], e.due, cyc);
        end
    end

    task automatic idle();
        wr_en   = 1'b0;
        wr_done = 1'b0;
        rd_en   = 1'b0;
        rd_done = 1'b0;
    endtask

    task automatic push_rd(input int a, input logic [DW-1:0] d);
        exp_t e;
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        e.data  = d;
        e.due   = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        wr_addr = '0;
        rd_addr = '0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({wr_ready, rd_avail, full_cnt, err, rd_valid} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags got %b exp 100000",
                     {wr_ready, rd_avail, full_cnt, err, rd_valid});
        end
        checks++;
        if (rd_data !== '0) begin
            failures++;
            $display("FAIL reset_rd_data got lo=%h exp 0", rd_data[15:0]);
        end
    endtask

    task automatic test_fill_bank0();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = mk(16'hA000, i);
            @(negedge clk);
        end
        idle();
        checks++;
        if (full_cnt !== 2'd0) begin
            failures++;
            $display("FAIL fill_pre_done full_cnt got %0d exp 0", full_cnt);
        end
        wr_done = 1'b1;
        @(negedge clk);
        idle();
        checks++;
        if (full_cnt !== 2'd1) begin
            failures++;
            $display("FAIL fill_full_cnt got %0d exp 1", full_cnt);
        end
        checks++;
        if ({rd_avail, wr_ready, err} !== 3'b110) begin
            failures++;
            $display("FAIL fill_flags got %b exp 110", {rd_avail, wr_ready, err});
        end
    endtask

    task automatic test_read_addr5();
        push_rd(5, mk(16'hA000, 5));
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== mk(16'hA000, 5)) begin
            failures++;
            $display("FAIL read_hold got v=%b lo=%h exp v=0 lo=a005",
                     rd_valid, rd_data[15:0]);
        end
    endtask

    task automatic test_both_full();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = mk(16'hB000, i);
            wr_done = (i == DEPTH - 1);
            @(negedge clk);
        end
        idle();
        checks++;
        if (full_cnt !== 2'd2) begin
            failures++;
            $display("FAIL both_full_cnt got %0d exp 2", full_cnt);
        end
        checks++;
        if ({wr_ready, rd_avail, err} !== 3'b010) begin
            failures++;
            $display("FAIL both_flags got %b exp 010", {wr_ready, rd_avail, err});
        end
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = mk(16'hEEE0, 0);
        wr_done = 1'b1;
        @(negedge clk);
        idle();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL overflow_err got %b exp 1", err);
        end
        checks++;
        if (full_cnt !== 2'd2 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL overflow_cnt got %0d/%b exp 2/0", full_cnt, wr_ready);
        end
        push_rd(0, mk(16'hA000, 0));
        @(negedge clk);
        push_rd(15, mk(16'hA000, 15));
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_read_with_done();
        push_rd(3, mk(16'hA000, 3));
        rd_done = 1'b1;
        @(negedge clk);
        idle();
        checks++;
        if (full_cnt !== 2'd1) begin
            failures++;
            $display("FAIL rdone_full_cnt got %0d exp 1", full_cnt);
        end
        checks++;
        if ({rd_avail, wr_ready} !== 2'b11) begin
            failures++;
            $display("FAIL rdone_flags got %b exp 11", {rd_avail, wr_ready});
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_simul_done();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = mk(16'hC000, i);
            wr_done = (i == DEPTH - 1);
            rd_done = (i == DEPTH - 1);
            if (i == 0) push_rd(7, mk(16'hB000, 7));
            if (i == 1) push_rd(15, mk(16'hB000, 15));
            @(negedge clk);
        end
        idle();
        checks++;
        if (full_cnt !== 2'd1 || err !== 1'b1) begin
            failures++;
            $display("FAIL simul_full_cnt got %0d/%b exp 1/1", full_cnt, err);
        end
        push_rd(15, mk(16'hC000, 15));
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = mk(16'hD000, i);
            wr_done = (i == DEPTH - 1);
            if (i == 0) begin
                push_rd(2, mk(16'hC000, 2));
                rd_done = 1'b1;
            end
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (full_cnt !== 2'd0 || rd_avail !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_release got %0d/%b exp 0/0", full_cnt, rd_avail);
                end
            end
        end
        idle();
        checks++;
        if (full_cnt !== 2'd1) begin
            failures++;
            $display("FAIL b2b_full_cnt got %0d exp 1", full_cnt);
        end
        push_rd(9, mk(16'hD000, 9));
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        rd_en   = 1'b1;
        rd_addr = AW'(4);
        if (LAT == 1) push_rd(4, mk(16'hD000, 4));
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== '0) begin
            failures++;
            $display("FAIL rst_inflight_rd got v=%b lo=%h exp v=0 lo=0",
                     rd_valid, rd_data[15:0]);
        end
        checks++;
        if ({full_cnt, err, rd_avail, wr_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL rst_inflight_state got %b exp 00001",
                     {full_cnt, err, rd_avail, wr_ready});
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_err_empty();
        rd_en   = 1'b1;
        rd_addr = AW'(1);
        rd_done = 1'b1;
        @(negedge clk);
        idle();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL underflow_err got %b exp 1", err);
        end
        checks++;
        if ({full_cnt, rd_avail, wr_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL underflow_state got %b exp 0001",
                     {full_cnt, rd_avail, wr_ready});
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_done = 1'b0;
        rd_en   = 1'b0;
        rd_done = 1'b0;
        wr_addr = '0;
        rd_addr = '0;
        wr_data = '0;
        @(negedge clk);
        test_reset();
        test_fill_bank0();
        test_read_addr5();
        test_both_full();
        test_read_with_done();
        test_simul_done();
        test_back_to_back();
        test_reset_inflight();
        test_err_empty();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d pending exp 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
